// File: rtl/rx_block_lock.sv
// rx_block_lock: 64b/66b sync-header block lock with gearbox slip control
module rx_block_lock #(
    parameter int SH_CNT_MAX       = 64,
    parameter int SH_INVALID_MAX   = 16,
    parameter int SLIP_WAIT_CYCLES = 66,
    parameter int SLIP_CNT_WIDTH   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [1:0]                i_header,
    input  logic                      i_header_valid,
    output logic                      o_slip,
    output logic                      o_block_lock,
    output logic [SLIP_CNT_WIDTH-1:0] o_slip_count
);
    localparam int CW = $clog2(SH_CNT_MAX + 1);
    localparam int IW = $clog2(SH_INVALID_MAX + 1);
    localparam int WW = $clog2(SLIP_WAIT_CYCLES + 1);

    typedef enum logic [1:0] {TEST, SLIP, WAIT} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   sh_cnt, sh_cnt_n, cnt_inc;
    logic [IW-1:0]   inv_cnt, inv_cnt_n, inv_inc;
    logic [WW-1:0]   wait_cnt, wait_cnt_n;
    logic            lock_n, good;

    assign good    = ^i_header;
    assign cnt_inc = sh_cnt + CW'(1);
    assign inv_inc = inv_cnt + IW'(!good);
    assign o_slip  = state == SLIP;

    // Next-state and counter logic; a slip decision also drops lock and clears the window
    always_comb begin
        state_n    = state;
        sh_cnt_n   = sh_cnt;
        inv_cnt_n  = inv_cnt;
        wait_cnt_n = wait_cnt;
        lock_n     = o_block_lock;
        unique case (state)
            TEST: if (i_header_valid) begin
                if ((!o_block_lock && !good) || (o_block_lock && inv_inc == IW'(SH_INVALID_MAX))) begin
                    state_n   = SLIP;
                    lock_n    = 1'b0;
                    sh_cnt_n  = '0;
                    inv_cnt_n = '0;
                end else if (cnt_inc == CW'(SH_CNT_MAX)) begin
                    lock_n    = 1'b1;
                    sh_cnt_n  = '0;
                    inv_cnt_n = '0;
                end else begin
                    sh_cnt_n  = cnt_inc;
                    inv_cnt_n = inv_inc;
                end
            end
            SLIP: begin
                state_n    = WAIT;
                wait_cnt_n = '0;
                sh_cnt_n   = '0;
                inv_cnt_n  = '0;
            end
            WAIT: begin
                state_n    = wait_cnt == WW'(SLIP_WAIT_CYCLES - 1) ? TEST : WAIT;
                wait_cnt_n = wait_cnt + WW'(1);
            end
            default: state_n = TEST;
        endcase
    end

    // State register; the slip counter steps on the edge that enters SLIP so it moves with o_slip
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= TEST;
            sh_cnt       <= '0;
            inv_cnt      <= '0;
            wait_cnt     <= '0;
            o_block_lock <= 1'b0;
            o_slip_count <= '0;
        end else begin
            state        <= state_n;
            sh_cnt       <= sh_cnt_n;
            inv_cnt      <= inv_cnt_n;
            wait_cnt     <= wait_cnt_n;
            o_block_lock <= lock_n;
            if (state == TEST && state_n == SLIP && !(&o_slip_count))
                o_slip_count <= o_slip_count + SLIP_CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_rx_block_lock.sv
// tb_rx_block_lock: randomized check of rx_block_lock against a behavioural lock model
module tb_rx_block_lock;
    logic        clk = 1'b0, rst = 1'b1, hv = 1'b0;
    logic [1:0]  hdr = 2'b00;
    logic        slip, lock, slip2, lock2;
    logic [15:0] scnt;
    logic [1:0]  scnt2;
    int          tests = 0, fails = 0;

    bit m_lock, m_slip;
    int m_cnt, m_inv, m_ign, m_slips;

    always #5 clk = ~clk;

    rx_block_lock dut (
        .i_clk(clk), .i_reset(rst), .i_header(hdr), .i_header_valid(hv),
        .o_slip(slip), .o_block_lock(lock), .o_slip_count(scnt)
    );

    rx_block_lock #(.SLIP_CNT_WIDTH(2)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_header(hdr), .i_header_valid(hv),
        .o_slip(slip2), .o_block_lock(lock2), .o_slip_count(scnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // After a slip decision: 1 slip cycle plus 66 wait cycles ignore headers
    task automatic model(input bit r, input bit v, input logic [1:0] h);
        bit bad;
        m_slip = 0;
        if (r) begin
            m_lock = 0; m_cnt = 0; m_inv = 0; m_ign = 0; m_slips = 0;
        end else if (m_ign > 0) begin
            m_ign--;
        end else if (v) begin
            bad = (h == 2'b00) || (h == 2'b11);
            m_cnt++;
            m_inv += int'(bad);
            if ((!m_lock && bad) || (m_lock && m_inv == 16)) begin
                m_lock = 0; m_slip = 1; m_slips++;
                m_cnt = 0; m_inv = 0; m_ign = 67;
            end else if (m_cnt == 64) begin
                m_lock = 1; m_cnt = 0; m_inv = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [1:0] h);
        rst = r; hv = v; hdr = h;
        @(posedge clk);
        model(r, v, h);
        @(negedge clk);
        chk("lock",   32'(lock),  32'(m_lock));
        chk("slip",   32'(slip),  32'(m_slip));
        chk("count",  32'(scnt),  32'(m_slips > 65535 ? 65535 : m_slips));
        chk("count2", 32'(scnt2), 32'(m_slips > 3 ? 3 : m_slips));
        chk("lock2",  32'(lock2), 32'(m_lock));
    endtask

    initial begin
        int mode, vmode, bad_div;
        bit v, r;
        logic [1:0] h;
        step(1, 0, 2'b00);
        step(1, 0, 2'b00);
        for (int i = 0; i < 64; i++) begin
            step(0, 1, (i % 2) ? 2'b10 : 2'b01);
            step(0, 0, 2'b00);
        end
        for (int p = 0; p < 120; p++) begin
            mode    = int'($urandom_range(0, 3));
            vmode   = int'($urandom_range(0, 2));
            bad_div = mode == 0 ? 0 : mode == 1 ? 64 : mode == 2 ? 4 : 3;
            for (int c = 0; c < 150; c++) begin
                r = $urandom_range(0, 999) == 0;
                v = vmode == 0 ? 1'b1 : vmode == 1 ? c[0] : ($urandom_range(0, 7) != 0);
                if (bad_div != 0 && $urandom_range(0, bad_div - 1) == 0)
                    h = $urandom_range(0, 1) ? 2'b11 : 2'b00;
                else
                    h = $urandom_range(0, 1) ? 2'b10 : 2'b01;
                step(r, v, h);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
